rf_wr_arb: RTL

- Arbitrates the single register-file write port between two writers:
  - req0: the pipeline writeback stage.
  - req1: a long-latency unit (multiply/divide).
- Fixed priority to req0, with a starvation counter that guarantees req1 forward progress.
- Drives the rf write/writeregsel/writedata inputs from registered outputs, so the rf write always comes from flops.
- Flags writer protocol violations on a sticky err output.

---
 rtl/rf_wr_arb.sv | 107 ++++++++++
 1 files changed

// File: rtl/rf_wr_arb.sv
// Register-file write-port arbiter: writeback (req0) has priority over the
// long-latency unit (req1), with a starvation counter bounding req1's wait.
module rf_wr_arb #(
  parameter int WIDTH      = 16,
  parameter int STARVE_MAX = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [2:0]       req0_sel,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [2:0]       req1_sel,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             write,
  output logic [2:0]       writeregsel,
  output logic [WIDTH-1:0] writedata,
  output logic [3:0]       starve_cnt,
  output logic             err
);

  localparam logic [3:0] LP_SMAX = 4'(STARVE_MAX);

  logic             w_gnt0;
  logic             w_gnt1;
  logic             w_viol0;
  logic             w_viol1;

  logic             r_write;
  logic [2:0]       r_sel;
  logic [WIDTH-1:0] r_data;
  logic [3:0]       r_starve;
  logic             r_err;

  logic             r_stall0;
  logic [2:0]       r_sel0;
  logic [WIDTH-1:0] r_data0;
  logic             r_stall1;
  logic [2:0]       r_sel1;
  logic [WIDTH-1:0] r_data1;

  // req1 only overrides req0 once it has waited the full STARVE_MAX cycles
  assign w_gnt0 = !rst && req0_valid &&
                  (!req1_valid || (r_starve < LP_SMAX));
  assign w_gnt1 = !rst && req1_valid && !w_gnt0;

  assign w_viol0 = r_stall0 &&
                   (!req0_valid ||
                    (req0_sel != r_sel0) ||
                    (req0_data != r_data0));
  assign w_viol1 = r_stall1 &&
                   (!req1_valid ||
                    (req1_sel != r_sel1) ||
                    (req1_data != r_data1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_write  <= 1'b0;
      r_sel    <= '0;
      r_data   <= '0;
      r_starve <= '0;
      r_err    <= 1'b0;
      r_stall0 <= 1'b0;
      r_sel0   <= '0;
      r_data0  <= '0;
      r_stall1 <= 1'b0;
      r_sel1   <= '0;
      r_data1  <= '0;
    end else begin
      r_write <= w_gnt0 || w_gnt1;
      if (w_gnt0) begin
        r_sel  <= req0_sel;
        r_data <= req0_data;
      end else if (w_gnt1) begin
        r_sel  <= req1_sel;
        r_data <= req1_data;
      end

      if (w_gnt1 || !req1_valid) begin
        r_starve <= '0;
      end else if (r_starve < LP_SMAX) begin
        r_starve <= r_starve + 4'd1;
      end

      // snapshot each requester so a stalled request can be checked next cycle
      r_stall0 <= req0_valid && !w_gnt0;
      r_sel0   <= req0_sel;
      r_data0  <= req0_data;
      r_stall1 <= req1_valid && !w_gnt1;
      r_sel1   <= req1_sel;
      r_data1  <= req1_data;

      r_err <= r_err || w_viol0 || w_viol1;
    end
  end

  assign req0_ready  = w_gnt0;
  assign req1_ready  = w_gnt1;
  assign write       = r_write;
  assign writeregsel = r_sel;
  assign writedata   = r_data;
  assign starve_cnt  = r_starve;
  assign err         = r_err;

endmodule
